sdram_port_arbiter: RTL

Three-requester arbiter that shares the single SDRAM cpu/chipset port (addr/din/ds/we/oe/dout, slot strobe `cep`) between video fetch, CPU and disk DMA. It sits between the chipset and the `sdram` controller. It stages one command at a time so the command is stable when the controller samples it on `cep`. It acknowledges the issuing requester and returns read data to it a fixed number of cycles after issue.

---
 rtl/sdram_port_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM cpu port between video (0), CPU (1) and DMA (2), one staged command at a time.
// Define SDRAM_ARB_DMA_EN to let DMA participate; otherwise CPU is the only low-priority requester.
module sdram_port_arbiter #(
   parameter int ADDR_W = 25,
   parameter int RD_LAT = 6
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic                  cep,
   input  logic [2:0]            req,
   input  logic [2:0]            req_we,
   input  logic [3*ADDR_W-1:0]   req_addr,
   input  logic [47:0]           req_din,
   input  logic [5:0]            req_ds,
   output logic [2:0]            ack,
   output logic [2:0]            rvalid,
   output logic [15:0]           rdata,
   output logic [ADDR_W-1:0]     sdram_addr,
   output logic [15:0]           sdram_din,
   output logic [1:0]            sdram_ds,
   output logic                  sdram_we,
   output logic                  sdram_oe,
   input  logic [15:0]           sdram_dout
);
   typedef enum logic {EMPTY, STAGED} state_t;
   state_t     r_state;
   logic [1:0] r_stg_id;
   logic [1:0] r_trk_id;
   logic       r_trk_v;
   logic [3:0] r_trk_cnt;
   logic [2:0] w_elig;
   logic [1:0] w_win;
   logic       w_capture;
`ifdef SDRAM_ARB_DMA_EN
   localparam logic [2:0] PORTS = 3'b111;
   logic r_rr;
   // r_rr=1 means DMA is preferred over CPU on the next contested grant
   assign w_win = w_elig[0] ? 2'd0 : (w_elig[2] && (r_rr || !w_elig[1])) ? 2'd2 : 2'd1;
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) r_rr <= 1'b0;
      else if (r_state == STAGED && cep && r_stg_id != 2'd0) r_rr <= (r_stg_id == 2'd1);
`else
   localparam logic [2:0] PORTS = 3'b011;
   assign w_win = w_elig[0] ? 2'd0 : 2'd1;
`endif
   assign w_elig    = req & ~ack & PORTS;
   assign w_capture = r_trk_v && (r_trk_cnt == 4'(RD_LAT - 1));
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         r_state    <= EMPTY;
         r_stg_id   <= '0;
         r_trk_id   <= '0;
         r_trk_v    <= 1'b0;
         r_trk_cnt  <= '0;
         ack        <= '0;
         rvalid     <= '0;
         rdata      <= '0;
         sdram_addr <= '0;
         sdram_din  <= '0;
         sdram_ds   <= '0;
         sdram_we   <= 1'b0;
         sdram_oe   <= 1'b0;
      end else begin
         ack    <= '0;
         rvalid <= '0;
         if (w_capture) begin
            rdata   <= sdram_dout;
            rvalid  <= (3'b001 << r_trk_id) & PORTS;
            r_trk_v <= 1'b0;
         end else if (r_trk_v) r_trk_cnt <= r_trk_cnt + 4'd1;
         if (r_state == EMPTY) begin
            if (|w_elig) begin
               r_state    <= STAGED;
               r_stg_id   <= w_win;
               sdram_addr <= req_addr[w_win*ADDR_W +: ADDR_W];
               sdram_din  <= req_din[w_win*16 +: 16];
               sdram_ds   <= req_ds[w_win*2 +: 2];
               sdram_we   <= req_we[w_win];
               sdram_oe   <= ~req_we[w_win];
            end
         end else if (cep) begin
            r_state  <= EMPTY;
            ack      <= (3'b001 << r_stg_id) & PORTS;
            sdram_we <= 1'b0;
            sdram_oe <= 1'b0;
            // a reload here overrides the clear from a same-cycle capture
            if (sdram_oe) begin
               r_trk_v   <= 1'b1;
               r_trk_cnt <= '0;
               r_trk_id  <= r_stg_id;
            end
         end
      end
endmodule
